// File: rtl/ldlt_pkg.sv
// ldlt_pkg: shared state encoding, column-major L addressing and fixed-point helpers for the LDLT blocks.
package ldlt_pkg;

   localparam int DATA_LEN_DEF = 32;
   localparam int FRACTION_DEF = 16;
   localparam int PW = 128;

   typedef enum logic [1:0] {IDLE, LOADB, FWD, BACK} state_t;

   // Strictly-lower L, packed column by column; valid only for i > j.
   function automatic int ldlt_addr(input int i, input int j, input int dim);
      return j * dim - j * (j + 1) / 2 + i - j - 1;
   endfunction

   function automatic logic signed [PW-1:0] rtz_shift(input logic signed [PW-1:0] p, input int frac);
      logic signed [PW-1:0] bias;
      bias = p[PW-1] ? (PW'(1) << frac) - PW'(1) : '0;
      return (p + bias) >>> frac;
   endfunction

endpackage

// File: rtl/fx_mul.sv
// fx_mul: signed fixed-point multiply, full-width product rounded toward zero then truncated.
module fx_mul import ldlt_pkg::*; #(
   parameter int DATA_LEN = DATA_LEN_DEF,
   parameter int FRACTION = FRACTION_DEF
) (
   input  logic signed [DATA_LEN-1:0] a,
   input  logic signed [DATA_LEN-1:0] b,
   output logic signed [DATA_LEN-1:0] p
);

   logic signed [2*DATA_LEN-1:0] prod;

   assign prod = (2*DATA_LEN)'(a) * (2*DATA_LEN)'(b);
   assign p = DATA_LEN'(rtz_shift(PW'(prod), FRACTION));

endmodule

// File: rtl/ldlt_solver.sv
// ldlt_solver: solves A*x = b from a streamed LDLT factor, forward/diagonal on the fly, back substitution after.
module ldlt_solver import ldlt_pkg::*; #(
   parameter int DATA_LEN = DATA_LEN_DEF,
   parameter int DIM = 600,
   parameter int FRACTION = FRACTION_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic                i_b_valid,
   input  logic [DATA_LEN-1:0] i_b_data,
   input  logic                i_valid,
   input  logic [DATA_LEN-1:0] i_data,
   output logic                o_valid,
   output logic [DATA_LEN-1:0] o_data,
   output logic                o_last,
   output logic                o_err
);

   localparam int LSZ = DIM > 1 ? DIM * (DIM - 1) / 2 : 1;
   localparam int CW = $clog2(DIM + 1);
   localparam int YW = DIM > 1 ? $clog2(DIM) : 1;
   localparam int LW = LSZ > 1 ? $clog2(LSZ) : 1;
   localparam int DW2 = 2 * DATA_LEN;
   localparam logic [CW-1:0] LAST = CW'(DIM - 1);
   localparam logic [CW-1:0] END_K = CW'(DIM);

   state_t state, state_nx;
   logic [CW-1:0] cnt, i, j, r, k;
   logic signed [DATA_LEN-1:0] y_mem [DIM];
   logic signed [DATA_LEN-1:0] l_mem [LSZ];
   logic signed [DATA_LEN-1:0] acc, yj_r, word, y_i, y_j, y_k, y_rm1, l_kr, fwd_p, back_p, quot;
   logic signed [DW2-1:0] num, den;
   logic [LW-1:0] fwd_addr, back_addr;
   logic fwd_go, d_word, last_word, emit, y_we;
   logic [CW-1:0] y_wa;
   logic signed [DATA_LEN-1:0] y_wd;

   assign word = i_data;
   assign y_i = y_mem[YW'(i)];
   assign y_j = y_mem[YW'(j)];
   assign y_k = y_mem[YW'(k)];
   assign y_rm1 = y_mem[YW'(r - 1'b1)];
   assign fwd_addr = LW'(ldlt_addr(int'(i), int'(j), DIM));
   assign back_addr = LW'(ldlt_addr(int'(k), int'(r), DIM));
   assign l_kr = l_mem[back_addr];

   assign fwd_go = state == FWD && i_valid;
   assign d_word = i == j;
   assign last_word = fwd_go && d_word && j == LAST;
   assign emit = state == BACK && k == END_K;

   // A zero pivot yields 0 rather than whatever the divider produces.
   assign num = DW2'(y_j) <<< FRACTION;
   assign den = DW2'(word);
   assign quot = word == '0 ? '0 : DATA_LEN'(num / den);

   fx_mul #(.DATA_LEN(DATA_LEN), .FRACTION(FRACTION)) u_fwd_mul (.a(word), .b(yj_r), .p(fwd_p));
   fx_mul #(.DATA_LEN(DATA_LEN), .FRACTION(FRACTION)) u_back_mul (.a(l_kr), .b(y_k), .p(back_p));

   always_comb begin
      state_nx = state;
      if (state == IDLE && i_start) state_nx = LOADB;
      if (state == LOADB && i_b_valid && cnt == LAST) state_nx = FWD;
      if (last_word) state_nx = BACK;
      if (emit && r == '0) state_nx = IDLE;
   end

   always_comb begin
      y_we = (state == LOADB && i_b_valid) || fwd_go || emit;
      y_wa = state == LOADB ? cnt : emit ? r : d_word ? j : i;
      y_wd = state == LOADB ? i_b_data : emit ? acc : d_word ? quot : y_i - fwd_p;
   end

   always_ff @(posedge clk) begin
      if (y_we) y_mem[YW'(y_wa)] <= y_wd;
      if (fwd_go && !d_word) l_mem[fwd_addr] <= word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         i <= '0;
         j <= '0;
         r <= '0;
         k <= '0;
         acc <= '0;
         yj_r <= '0;
         o_valid <= 1'b0;
         o_data <= '0;
         o_last <= 1'b0;
         o_err <= 1'b0;
      end else begin
         state <= state_nx;
         o_valid <= emit;
         o_last <= emit && r == '0;
         if (emit) o_data <= acc;
         if (state == IDLE && i_start) begin
            cnt <= '0;
            i <= '0;
            j <= '0;
            o_err <= 1'b0;
         end
         if (state == LOADB && i_b_valid) cnt <= cnt + 1'b1;
         if (fwd_go) begin
            if (d_word) yj_r <= y_j;
            if (d_word && word == '0) o_err <= 1'b1;
            i <= i == LAST ? j + 1'b1 : i + 1'b1;
            j <= i == LAST ? j + 1'b1 : j;
         end
         // The last pivot's quotient goes straight into acc; Y[DIM-1] is not written yet.
         if (last_word) begin
            acc <= quot;
            r <= LAST;
            k <= END_K;
         end
         if (state == BACK && !emit) begin
            acc <= acc - back_p;
            k <= k + 1'b1;
         end
         if (emit && r != '0) begin
            r <= r - 1'b1;
            k <= r;
            acc <= y_rm1;
         end
      end
   end

endmodule

// File: doc/ldlt_solver.md
Name: ldlt_solver

Overview:
- Consumes the L/D factor stream emitted by the team's LDLT factorization block (o_valid/o_data, column-major) and solves A·x = b by forward substitution, diagonal scaling and back substitution.
- Forward substitution and D scaling run on the fly as factor words arrive, at one word per cycle with no backpressure.
- Back substitution runs afterwards and streams x out in descending index order.

Parameters:
- DATA_LEN, 32, word width; signed two's-complement fixed point.
- DIM, 600, matrix dimension (6·NODE_NUM in the system).
- FRACTION, 16, number of fractional bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  starts a solve; honoured only in IDLE.
- i_b_valid  in  1  RHS word valid.
- i_b_data  in  DATA_LEN  b_i, in index order 0..DIM-1.
- i_valid  in  1  factor word valid (connects to LDLT o_valid).
- i_data  in  DATA_LEN  factor word (connects to LDLT o_data).
- o_valid  out  1  x word valid, one-cycle pulse per word.
- o_data  out  DATA_LEN  x_i, emitted in order i = DIM-1 down to 0.
- o_last  out  1  high together with o_valid on x_0.
- o_err  out  1  sticky flag, set on D_jj == 0; cleared on i_start.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Reset asserted mid-operation aborts to IDLE; array contents are don't-care.
- Storage:
  - Y[DIM] holds y, then z, then x.
  - Lmem[DIM(DIM-1)/2] holds L, column-major.
  - Both arrays: combinational read, synchronous write.
- Factor stream order: column j = 0..DIM-1, first D_jj, then L_ij for i = j+1..DIM-1.
- Fixed-point multiply (fxmul):
  - Full 2·DATA_LEN signed product.
  - If the product is negative, add 2^FRACTION-1 first; then arithmetic shift right by FRACTION, i.e. round toward zero.
  - Truncate to DATA_LEN.
- Divide: (y <<< FRACTION) / D, computed in 2·DATA_LEN signed arithmetic, truncated to DATA_LEN, single cycle, combinational.
- States:
  - IDLE: on i_start go to LOADB, clear o_err and counters.
  - LOADB:
    - Each i_b_valid writes Y[cnt] and increments cnt.
    - After word DIM-1, go to FWD with j = i = 0.
    - i_valid is ignored in this state.
  - FWD: each i_valid cycle:
    - If i == j (D word):
      - Latch yj_r = Y[j].
      - Write Y[j] = Y[j]/D. If D == 0, write 0 and set o_err.
    - Otherwise (L word):
      - Lmem[addr(i,j)] = word.
      - Y[i] = Y[i] - fxmul(word, yj_r).
    - Counter update: i++; when i == DIM-1, move to j+1 with i = j+1.
    - Cycles without i_valid: counters hold.
    - Accepting word (DIM-1, DIM-1): load acc with the freshly computed z_{DIM-1} (bypass, not a re-read of Y) and go to BACK with r = DIM-1, k = DIM.
  - BACK:
    - If k < DIM: acc = acc - fxmul(Lmem[addr(k,r)], Y[k]); k++.
    - Else:
      - Write Y[r] = acc; register o_valid = 1, o_data = acc, o_last = (r == 0).
      - If r == 0, go to IDLE. Otherwise r--, k = r (new) + 1, acc = Y[r-1].
- addr(i,j) = j·DIM - j(j+1)/2 + i - j - 1; requires i > j.
- Latency:
  - Row r costs (DIM-1-r)+1 cycles.
  - x_{DIM-1} appears on o_valid 2 cycles after the last factor word is accepted.
  - Total BACK phase = DIM(DIM+1)/2 cycles.
- Ignored inputs:
  - i_start outside IDLE.
  - i_b_valid outside LOADB.
  - i_valid outside FWD.
  - If i_b_valid and i_valid are both high, only the one matching the current state is used.
- Overflow: wraps; no saturation.

Decomposition:
- Package ldlt_pkg:
  - State encodings.
  - Column-major addr function, shared with the LDLT block.
  - Round-toward-zero shift helper.
  - Default DATA_LEN/FRACTION constants.
- One sub-module, fx_mul: signed fixed-point multiply with rounding; used twice (forward and back paths).

Test Plan:
1. Basic solve. DIM=2, FRACTION=16; b = [0x20000, 0x30000]; factors D0=0x10000, L10=0x8000, D1=0x20000.
   -> o_data 0x10000 (x1), then 0x18000 (x0) with o_last.
   -> First o_valid exactly 2 cycles after the D1 word; second o_valid 2 cycles after the first.
2. Identity. DIM=3, all D=0x10000, all L=0; b = [0xFFFF0000, 0x8000, 0x30000].
   -> Outputs 0x30000, 0x8000, 0xFFFF0000.
   -> Exactly 3 o_valid pulses; o_err=0.
3. Zero pivot. DIM=2, D0=0 -> o_err=1, z0=0; solve still completes with 2 outputs. A new i_start clears o_err.
4. Gapped stream. Repeat case 1 with i_valid deasserted for 3 random cycles between words -> identical outputs.
5. Reset mid-FWD. Deassert rst_n mid-FWD -> outputs 0 and state IDLE immediately; a full case-1 rerun gives correct results.
6. Stray inputs. i_start during BACK, and i_valid pulses during IDLE/LOADB -> ignored; case-1 outputs unchanged.
